axi_mm2s_rd_responder: RTL

AXI_MM2S_RD_RESPONDER -- requirements
Module: axi_mm2s_rd_responder

---
 rtl/params_pkg.sv | 17 +
 rtl/dma_mem_array.sv | 23 ++
 rtl/axi_mm2s_rd_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared encodings for the MM2S read responder: AXI burst types, response codes, FSM states.
package params_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/dma_mem_array.sv
// Backing word store: one write port, one registered read port (read-before-write on collision).
module dma_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Write and registered read share the edge; a same-word read sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_mm2s_rd_responder.sv
// AXI4 read-only slave answering bursts from an internal preloadable memory.
module axi_mm2s_rd_responder
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         axi_aclk,
  input  logic                         axi_resetn,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic [2:0]                   s_axi_arprot,
  input  logic [3:0]                   s_axi_arcache,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         mem_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
  input  logic [31:0]                  mem_wr_data,
  output logic [15:0]                  burst_done_cnt
);

  localparam int unsigned MAW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    rvalid_q;
  logic                    rlast_q;
  logic [1:0]              rresp_q;
  logic                    zero_q;
  logic [15:0]             done_q;

  logic                    ar_hs;
  logic                    r_hs;
  logic                    load;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [2:0]              beat_size;
  logic [1:0]              beat_burst;
  logic [1:0]              beat_resp;
  logic                    rd_en;
  logic [31:0]             mem_q;
  logic                    unused_sidebands;

  assign unused_sidebands = ^{s_axi_arprot, s_axi_arcache};

  assign s_axi_arready  = (state == ST_IDLE) && axi_resetn;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rlast    = rlast_q;
  assign s_axi_rresp    = rresp_q;
  assign s_axi_rdata    = zero_q ? '0 : mem_q;
  assign burst_done_cnt = done_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = rvalid_q && s_axi_rready;
  assign load  = ar_hs || (state == ST_BURST && r_hs && !rlast_q);

  // Address, type and response of the beat whose data is fetched on this edge:
  // the AR request itself when idle, otherwise the following beat of the burst.
  always_comb begin
    next_addr = addr_q;
    if (burst_q == BURST_INCR) next_addr = addr_q + (ONE_A << size_q);
    if (state == ST_IDLE) begin
      beat_addr  = s_axi_araddr;
      beat_size  = s_axi_arsize;
      beat_burst = s_axi_arburst;
    end else begin
      beat_addr  = next_addr;
      beat_size  = size_q;
      beat_burst = burst_q;
    end
    word_idx  = beat_addr >> 2;
    beat_resp = RESP_OKAY;
    if (beat_burst[1] || beat_size > 3'd2) beat_resp = RESP_SLVERR;
    else if (word_idx >= DEPTH_A)          beat_resp = RESP_DECERR;
    rd_en = load && (beat_resp == RESP_OKAY);
  end

  dma_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (MAW)
  ) u_mem (
    .clk     (axi_aclk),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .rd_en   (rd_en),
    .rd_addr (word_idx[MAW-1:0]),
    .rd_data (mem_q)
  );

  // Burst FSM: accepts AR in IDLE, walks beats in BURST; rlast/rresp are precomputed
  // for the beat being presented so they stay put while the master stalls.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      zero_q   <= 1'b1;
      done_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            addr_q   <= s_axi_araddr;
            len_q    <= s_axi_arlen;
            size_q   <= s_axi_arsize;
            burst_q  <= s_axi_arburst;
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            rlast_q  <= (s_axi_arlen == 8'd0);
            rresp_q  <= beat_resp;
            zero_q   <= (beat_resp != RESP_OKAY);
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              done_q   <= done_q + 16'd1;
              state    <= ST_IDLE;
            end else begin
              addr_q  <= next_addr;
              cnt_q   <= cnt_q + 8'd1;
              rlast_q <= ((cnt_q + 8'd1) == len_q);
              rresp_q <= beat_resp;
              zero_q  <= (beat_resp != RESP_OKAY);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
